// File: rtl/serial_frame_transceiver.sv
// Single-wire serial frame transceiver: sends or receives one frame of 1..WIDTH bits per start
// request, drives the PAD output-enable while transmitting, and exposes FSM state for debug.
`timescale 1ns/1ps
module serial_frame_transceiver #(
  parameter int WIDTH     = 64,
  parameter int CNT_W     = 7,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_mode,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_framesize,
  input  logic [WIDTH-1:0] i_tx_parallel,
  output logic             o_serial_out,
  output logic             o_serial_oe,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_rx_parallel,
  output logic             o_busy,
  output logic             o_complete,
  output logic [1:0]       o_state
);

  // Handshake: i_start is honoured only when o_state is IDLE and i_enable is high; it is never
  // queued. o_complete pulses for exactly one cycle when a frame ends.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_t           r_state;
  logic             r_mode;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_serial_out;
  logic             r_serial_oe;
  logic             r_busy;
  logic             r_complete;
  logic [WIDTH-1:0] r_rx_parallel;

  logic [CNT_W-1:0] w_len_sel;
  logic [WIDTH-1:0] w_tx_load;
  logic [WIDTH-1:0] w_rx_next;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_rx_result;

  always_comb begin
    // Out-of-range frame sizes (0 or above WIDTH) fall back to a full-width frame.
    w_len_sel = (i_framesize == '0 || i_framesize > WIDTH_C) ? WIDTH_C : i_framesize;
    if (MSB_FIRST) begin
      w_tx_load = i_tx_parallel << (WIDTH_C - w_len_sel);
      w_rx_next = {r_shreg[WIDTH-2:0], i_serial_in};
    end else begin
      w_tx_load = i_tx_parallel;
      w_rx_next = {i_serial_in, r_shreg[WIDTH-1:1]};
    end
    w_mask      = (r_len == WIDTH_C) ? '1 : ((WIDTH'(1) << r_len) - WIDTH'(1));
    w_rx_result = MSB_FIRST ? (w_rx_next & w_mask) : (w_rx_next >> (WIDTH_C - r_len));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_mode        <= 1'b0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_shreg       <= '0;
      r_serial_out  <= 1'b0;
      r_serial_oe   <= 1'b0;
      r_busy        <= 1'b0;
      r_complete    <= 1'b0;
      r_rx_parallel <= '0;
    end else if (r_state == DONE) begin
      // DONE always lasts one cycle, independent of i_enable.
      r_state    <= IDLE;
      r_complete <= 1'b0;
    end else if (i_enable) begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_mode  <= i_mode;
            r_len   <= w_len_sel;
            r_cnt   <= '0;
            r_state <= SHIFT;
            r_busy  <= 1'b1;
            if (!i_mode) begin
              // First bit is presented on the start edge itself.
              r_serial_oe <= 1'b1;
              if (MSB_FIRST) begin
                r_serial_out <= w_tx_load[WIDTH-1];
                r_shreg      <= w_tx_load << 1;
              end else begin
                r_serial_out <= w_tx_load[0];
                r_shreg      <= w_tx_load >> 1;
              end
            end else begin
              r_serial_oe  <= 1'b0;
              r_serial_out <= 1'b0;
              r_shreg      <= '0;
            end
          end
        end
        SHIFT: begin
          if (r_cnt == r_len - CNT_W'(1)) begin
            r_state      <= DONE;
            r_busy       <= 1'b0;
            r_complete   <= 1'b1;
            r_serial_oe  <= 1'b0;
            r_serial_out <= 1'b0;
            if (r_mode) r_rx_parallel <= w_rx_result;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (!r_mode) begin
              r_serial_out <= MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
              r_shreg      <= MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
            end else begin
              r_shreg <= w_rx_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_serial_out  = r_serial_out;
  assign o_serial_oe   = r_serial_oe;
  assign o_rx_parallel = r_rx_parallel;
  assign o_busy        = r_busy;
  assign o_complete    = r_complete;
  assign o_state       = r_state;

endmodule

// File: tb/tb_serial_frame_transceiver.sv
// Two loopback pairs (MSB-first and LSB-first): instance a transmits, instance b receives through a
// pull-down PAD model. Each frame's expected cycle timeline is built from the frame-level rules.
`timescale 1ns/1ps
module tb_serial_frame_transceiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en[2], a_start[2], b_start[2], a_mode[2], b_mode[2];
  logic [6:0]  a_fs[2], b_fs[2];
  logic [63:0] a_tx[2], b_tx[2], a_rx[2], b_rx[2], last_rx[2];
  logic        a_out[2], a_oe[2], b_out[2], b_oe[2];
  logic        a_busy[2], b_busy[2], a_cmp[2], b_cmp[2];
  logic [1:0]  a_st[2], b_st[2];
  logic        pad_ab[2], pad_ba[2];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_pair
    assign pad_ab[g] = a_oe[g] ? a_out[g] : 1'b0;
    assign pad_ba[g] = b_oe[g] ? b_out[g] : 1'b0;

    serial_frame_transceiver #(.WIDTH(64), .CNT_W(7), .MSB_FIRST(g == 0)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[g]), .i_mode(a_mode[g]),
      .i_start(a_start[g]), .i_framesize(a_fs[g]), .i_tx_parallel(a_tx[g]),
      .o_serial_out(a_out[g]), .o_serial_oe(a_oe[g]), .i_serial_in(pad_ba[g]),
      .o_rx_parallel(a_rx[g]), .o_busy(a_busy[g]), .o_complete(a_cmp[g]), .o_state(a_st[g])
    );

    serial_frame_transceiver #(.WIDTH(64), .CNT_W(7), .MSB_FIRST(g == 0)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en[g]), .i_mode(b_mode[g]),
      .i_start(b_start[g]), .i_framesize(b_fs[g]), .i_tx_parallel(b_tx[g]),
      .o_serial_out(b_out[g]), .o_serial_oe(b_oe[g]), .i_serial_in(pad_ab[g]),
      .o_rx_parallel(b_rx[g]), .o_busy(b_busy[g]), .o_complete(b_cmp[g]), .o_state(b_st[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input int p);
    check("idle_a_oe", a_oe[p], 0);
    check("idle_a_out", a_out[p], 0);
    check("idle_a_busy", a_busy[p], 0);
    check("idle_a_cmp", a_cmp[p], 0);
    check("idle_a_state", a_st[p], 0);
    check("idle_b_oe", b_oe[p], 0);
    check("idle_b_busy", b_busy[p], 0);
    check("idle_b_cmp", b_cmp[p], 0);
    check("idle_b_state", b_st[p], 0);
  endtask

  // One frame on pair p: a transmits, b receives. stall_len enabled-low cycles while bit 2 is shown;
  // poke_busy re-requests start mid-frame; poke_done requests start in the DONE cycle;
  // abort_at >= 0 pulls reset while that bit index is on the wire.
  task automatic run_frame(input int p, input logic [6:0] fs, input logic [63:0] data,
                           input int stall_len, input bit poke_busy, input bit poke_done,
                           input int abort_at);
    int          len, pos, stall_left;
    logic        bits[$];
    logic [63:0] exp_rx;
    len = (fs == 0 || fs > 64) ? 64 : int'(fs);
    for (int j = 0; j < len; j++) bits.push_back((p == 0) ? data[len-1-j] : data[j]);
    exp_rx = (len == 64) ? data : (data & ((64'd1 << len) - 64'd1));

    @(negedge clk);
    check("rx_hold", b_rx[p], last_rx[p]);
    en[p] = 1'b1;
    a_start[p] = 1'b1; a_mode[p] = 1'b0; a_fs[p] = fs; a_tx[p] = data;
    b_start[p] = 1'b1; b_mode[p] = 1'b1; b_fs[p] = fs; b_tx[p] = {$urandom, $urandom};
    pos = 0;
    stall_left = stall_len;
    @(negedge clk);
    while (pos < len) begin
      a_tx[p] = {$urandom, $urandom};
      check("tx_oe", a_oe[p], 1);
      check("tx_bit", a_out[p], bits[pos]);
      check("tx_busy", a_busy[p], 1);
      check("tx_cmp", a_cmp[p], 0);
      check("tx_state", a_st[p], 1);
      check("rx_busy", b_busy[p], 1);
      check("rx_oe", b_oe[p], 0);
      check("rx_out", b_out[p], 0);
      check("rx_cmp", b_cmp[p], 0);
      if (pos == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_oe", a_oe[p], 0);
        check("abort_out", a_out[p], 0);
        check("abort_busy", a_busy[p], 0);
        check("abort_rx_busy", b_busy[p], 0);
        check("abort_rx_data", b_rx[p], 0);
        a_start[p] = 1'b0; b_start[p] = 1'b0; en[p] = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_cmp_a", a_cmp[p], 0);
          check("abort_no_cmp_b", b_cmp[p], 0);
          check("abort_state", a_st[p], 0);
        end
        rst_n = 1'b1;
        last_rx[0] = '0;
        last_rx[1] = '0;
        return;
      end
      a_start[p] = poke_busy && (pos == 1);
      b_start[p] = poke_busy && (pos == 1);
      if (pos == 2 && stall_left > 0) begin
        en[p] = 1'b0;
        stall_left--;
      end else begin
        en[p] = 1'b1;
        pos++;
      end
      @(negedge clk);
    end
    check("done_a_cmp", a_cmp[p], 1);
    check("done_a_oe", a_oe[p], 0);
    check("done_a_out", a_out[p], 0);
    check("done_a_busy", a_busy[p], 0);
    check("done_a_state", a_st[p], 2);
    check("done_a_rx_untouched", a_rx[p], 0);
    check("done_b_cmp", b_cmp[p], 1);
    check("done_b_busy", b_busy[p], 0);
    check("done_rx_data", b_rx[p], exp_rx);
    last_rx[p] = exp_rx;
    a_start[p] = poke_done; b_start[p] = poke_done;
    en[p] = 1'($urandom_range(0, 1));
    @(negedge clk);
    a_start[p] = 1'b0; b_start[p] = 1'b0; en[p] = 1'b1;
    check_idle(p);
  endtask

  task automatic idle_start_blocked(input int p);
    @(negedge clk);
    en[p] = 1'b0; a_start[p] = 1'b1; a_mode[p] = 1'b0; a_fs[p] = 7'd8; a_tx[p] = {$urandom, $urandom};
    @(negedge clk);
    check("blocked_busy", a_busy[p], 0);
    check("blocked_oe", a_oe[p], 0);
    a_start[p] = 1'b0; en[p] = 1'b1;
    @(negedge clk);
    check("blocked_state", a_st[p], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      en[p] = 1'b1; a_start[p] = 1'b0; b_start[p] = 1'b0; a_mode[p] = 1'b0; b_mode[p] = 1'b1;
      a_fs[p] = '0; b_fs[p] = '0; a_tx[p] = '0; b_tx[p] = '0; last_rx[p] = '0;
    end
    repeat (2) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      check_idle(p);
      check("reset_rx_data", b_rx[p], 0);
    end
    rst_n = 1'b1;

    run_frame(0, 7'd8, 64'hA5, 0, 0, 0, -1);
    run_frame(0, 7'd64, 64'hF0F0F0F0F0F0F0F0, 0, 0, 0, -1);
    run_frame(1, 7'd4, 64'h3, 0, 0, 0, -1);
    run_frame(0, 7'd0, {$urandom, $urandom}, 0, 0, 0, -1);
    run_frame(0, 7'd100, {$urandom, $urandom}, 0, 0, 0, -1);
    run_frame(1, 7'd0, {$urandom, $urandom}, 0, 0, 0, -1);
    run_frame(0, 7'd8, {$urandom, $urandom}, 3, 0, 0, -1);
    run_frame(1, 7'd8, {$urandom, $urandom}, 3, 0, 0, -1);
    idle_start_blocked(0);
    run_frame(0, 7'd8, {$urandom, $urandom}, 0, 1, 0, 5);
    run_frame(0, 7'd8, {$urandom, $urandom}, 0, 0, 0, -1);
    run_frame(1, 7'd1, 64'h1, 0, 0, 1, -1);

    for (int i = 0; i < 24; i++) begin
      run_frame(int'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), {$urandom, $urandom},
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
